pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/hazard_detect.sv | 16 +
 rtl/pipeline_control.sv | 140 ++++++++++++++
 tb/tb_pipeline_control.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the fetch/decode pipeline controller.
package pipe_ctrl_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned REG_IDX_W = 5;
    localparam logic [31:0] NOP_INSN  = 32'h00000033;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detect between ID/EX and IF/ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 idex_mem_read_i,
    input  logic [REG_IDX_W-1:0] idex_rd_i,
    input  logic [REG_IDX_W-1:0] ifid_rs1_i,
    input  logic [REG_IDX_W-1:0] ifid_rs2_i,
    output logic                 hazard_o
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hazard_o = idex_mem_read_i && (idex_rd_i != '0) &&
                      ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

endmodule

// File: rtl/pipeline_control.sv
// Pipeline stall/flush controller: registered FSM driving fetch-stage
// stall, flush, redirect and ID/EX bubble, plus saturating event counters.
module pipeline_control
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES    = 2,
    parameter int unsigned LU_STALL_CYCLES = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ex_branch_taken,
    input  logic [XLEN-1:0]      i_ex_branch_target,
    input  logic                 i_idex_mem_read,
    input  logic [REG_IDX_W-1:0] i_idex_rd,
    input  logic [REG_IDX_W-1:0] i_ifid_rs1,
    input  logic [REG_IDX_W-1:0] i_ifid_rs2,
    input  logic                 i_imem_busy,
    output logic                 o_stall,
    output logic                 o_flush,
    output logic                 o_jmp,
    output logic [XLEN-1:0]      o_address,
    output logic                 o_idex_bubble,
    output logic [31:0]          o_stall_count,
    output logic [31:0]          o_flush_count
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [2:0] LU_LOAD    = 3'(LU_STALL_CYCLES);

    state_t          state_q;
    logic [2:0]      cnt_q;
    logic [XLEN-1:0] addr_q;
    logic            jmp_q;
    logic            stall_q;
    logic            flush_q;
    logic            bubble_q;
    logic [31:0]     stall_count_q;
    logic [31:0]     flush_count_q;
    logic            lu_hazard;

    hazard_detect u_hazard_detect (
        .idex_mem_read_i (i_idex_mem_read),
        .idex_rd_i       (i_idex_rd),
        .ifid_rs1_i      (i_ifid_rs1),
        .ifid_rs2_i      (i_ifid_rs2),
        .hazard_o        (lu_hazard)
    );

    // Outputs are registered alongside the state; the stall counter is bumped
    // on the same edge that raises stall_q so the count tracks the visible stall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            addr_q        <= '0;
            jmp_q         <= 1'b0;
            stall_q       <= 1'b0;
            flush_q       <= 1'b0;
            bubble_q      <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            jmp_q    <= 1'b0;
            stall_q  <= 1'b0;
            flush_q  <= 1'b0;
            bubble_q <= 1'b0;
            if (i_ex_branch_taken) begin
                state_q       <= FLUSH;
                cnt_q         <= FLUSH_LOAD;
                addr_q        <= i_ex_branch_target;
                jmp_q         <= 1'b1;
                flush_q       <= 1'b1;
                bubble_q      <= 1'b1;
                flush_count_q <= sat_inc(flush_count_q);
            end else begin
                case (state_q)
                    RUN: begin
                        if (i_imem_busy) begin
                            state_q       <= MEM_WAIT;
                            stall_q       <= 1'b1;
                            stall_count_q <= sat_inc(stall_count_q);
                        end else if (lu_hazard) begin
                            state_q       <= LU_STALL;
                            cnt_q         <= LU_LOAD;
                            stall_q       <= 1'b1;
                            bubble_q      <= 1'b1;
                            stall_count_q <= sat_inc(stall_count_q);
                        end
                    end
                    LU_STALL: begin
                        if (cnt_q > 3'd1) begin
                            cnt_q         <= cnt_q - 3'd1;
                            stall_q       <= 1'b1;
                            bubble_q      <= 1'b1;
                            stall_count_q <= sat_inc(stall_count_q);
                        end else if (i_imem_busy) begin
                            state_q       <= MEM_WAIT;
                            stall_q       <= 1'b1;
                            stall_count_q <= sat_inc(stall_count_q);
                        end else if (lu_hazard) begin
                            cnt_q         <= LU_LOAD;
                            stall_q       <= 1'b1;
                            bubble_q      <= 1'b1;
                            stall_count_q <= sat_inc(stall_count_q);
                        end else begin
                            state_q <= RUN;
                        end
                    end
                    MEM_WAIT: begin
                        if (i_imem_busy) begin
                            stall_q       <= 1'b1;
                            stall_count_q <= sat_inc(stall_count_q);
                        end else begin
                            state_q <= RUN;
                        end
                    end
                    FLUSH: begin
                        if (cnt_q > 3'd1) begin
                            cnt_q    <= cnt_q - 3'd1;
                            flush_q  <= 1'b1;
                            bubble_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    assign o_stall       = stall_q;
    assign o_flush       = flush_q;
    assign o_jmp         = jmp_q;
    assign o_address     = addr_q;
    assign o_idex_bubble = bubble_q;
    assign o_stall_count = stall_count_q;
    assign o_flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed-vector bench for pipeline_control with hand-computed expectations.
module tb_pipeline_control;

    logic        clk;
    logic        rst;
    logic        br_taken;
    logic [63:0] br_target;
    logic        mem_read;
    logic [4:0]  idex_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        imem_busy;
    logic        stall;
    logic        flush;
    logic        jmp;
    logic [63:0] address;
    logic        bubble;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int unsigned vectors;
    int unsigned miscompares;

    pipeline_control #(
        .FLUSH_CYCLES    (2),
        .LU_STALL_CYCLES (1)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_ex_branch_taken  (br_taken),
        .i_ex_branch_target (br_target),
        .i_idex_mem_read    (mem_read),
        .i_idex_rd          (idex_rd),
        .i_ifid_rs1         (rs1),
        .i_ifid_rs2         (rs2),
        .i_imem_busy        (imem_busy),
        .o_stall            (stall),
        .o_flush            (flush),
        .o_jmp              (jmp),
        .o_address          (address),
        .o_idex_bubble      (bubble),
        .o_stall_count      (stall_count),
        .o_flush_count      (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // One clock edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        br_taken  = 1'b0;
        br_target = '0;
        mem_read  = 1'b0;
        idex_rd   = '0;
        rs1       = '0;
        rs2       = '0;
        imem_busy = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        check("rst_stall",  stall,       0);
        check("rst_flush",  flush,       0);
        check("rst_jmp",    jmp,         0);
        check("rst_addr",   address,     0);
        check("rst_bubble", bubble,      0);
        check("rst_scnt",   stall_count, 0);
        check("rst_fcnt",   flush_count, 0);
        rst = 1'b0;

        // Load x5 in ID/EX, IF/ID rs2=x5: one stall+bubble cycle.
        mem_read = 1'b1; idex_rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5;
        step();
        check("lu_stall",  stall,       1);
        check("lu_bubble", bubble,      1);
        check("lu_flush",  flush,       0);
        check("lu_scnt",   stall_count, 1);
        clear_inputs();
        step();
        check("lu_end_stall",  stall,       0);
        check("lu_end_bubble", bubble,      0);
        check("lu_end_scnt",   stall_count, 1);

        // Load to x0 never stalls.
        mem_read = 1'b1; idex_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        step();
        check("x0_stall", stall,       0);
        check("x0_scnt",  stall_count, 1);
        clear_inputs();

        // imem busy for three sampled edges -> three stall cycles.
        imem_busy = 1'b1;
        step();
        check("mw1_stall",  stall,  1);
        check("mw1_bubble", bubble, 0);
        step();
        check("mw2_stall", stall, 1);
        step();
        check("mw3_stall", stall, 1);
        imem_busy = 1'b0;
        step();
        check("mw4_stall", stall,       0);
        check("mw_scnt",   stall_count, 4);

        // Taken branch to 0x18: jmp once, flush two cycles.
        br_taken = 1'b1; br_target = 64'h18;
        step();
        check("br1_jmp",    jmp,         1);
        check("br1_addr",   address,     64'h18);
        check("br1_flush",  flush,       1);
        check("br1_bubble", bubble,      1);
        check("br1_stall",  stall,       0);
        check("br1_fcnt",   flush_count, 1);
        clear_inputs();
        step();
        check("br2_flush", flush,   1);
        check("br2_jmp",   jmp,     0);
        check("br2_addr",  address, 64'h18);
        step();
        check("br3_flush",  flush,   0);
        check("br3_jmp",    jmp,     0);
        check("br3_bubble", bubble,  0);
        check("br3_addr",   address, 64'h18);

        // Branch wins over busy and hazard on the same edge.
        do_reset();
        br_taken = 1'b1; br_target = 64'h100; imem_busy = 1'b1;
        mem_read = 1'b1; idex_rd = 5'd7; rs1 = 5'd7;
        step();
        check("pri_flush", flush,       1);
        check("pri_stall", stall,       0);
        check("pri_fcnt",  flush_count, 1);
        check("pri_scnt",  stall_count, 0);
        check("pri_addr",  address,     64'h100);

        // Second branch in first flush cycle restarts the sequence.
        do_reset();
        br_taken = 1'b1; br_target = 64'h18;
        step();
        check("rb1_addr", address, 64'h18);
        br_target = 64'h40;
        step();
        check("rb2_jmp",   jmp,         1);
        check("rb2_addr",  address,     64'h40);
        check("rb2_flush", flush,       1);
        check("rb2_fcnt",  flush_count, 2);
        clear_inputs();
        step();
        check("rb3_flush", flush, 1);
        check("rb3_jmp",   jmp,   0);
        step();
        check("rb4_flush", flush,   0);
        check("rb4_addr",  address, 64'h40);

        // Reset in the second flush cycle clears everything.
        do_reset();
        br_taken = 1'b1; br_target = 64'h18;
        step();
        clear_inputs();
        step();
        check("rf_pre_flush", flush, 1);
        rst = 1'b1;
        step();
        check("rf_flush",  flush,       0);
        check("rf_jmp",    jmp,         0);
        check("rf_bubble", bubble,      0);
        check("rf_addr",   address,     0);
        check("rf_fcnt",   flush_count, 0);
        rst = 1'b0;
        step();
        check("rf_run_flush", flush, 0);

        // Busy during load-use stall extends into MEM_WAIT.
        do_reset();
        mem_read = 1'b1; idex_rd = 5'd9; rs1 = 5'd9;
        step();
        check("lm1_stall",  stall,  1);
        check("lm1_bubble", bubble, 1);
        clear_inputs();
        imem_busy = 1'b1;
        step();
        check("lm2_stall",  stall,  1);
        check("lm2_bubble", bubble, 0);
        imem_busy = 1'b0;
        step();
        check("lm3_stall", stall,       0);
        check("lm_scnt",   stall_count, 2);

        // Reset mid-stall overrides a simultaneous busy.
        imem_busy = 1'b1;
        step();
        check("rs_pre_stall", stall, 1);
        rst = 1'b1;
        step();
        check("rs_stall", stall,       0);
        check("rs_scnt",  stall_count, 0);
        rst = 1'b0;
        clear_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
